// File: rtl/snoop_bus_ctrl_if.sv
// Bundle of the request, broadcast, snoop-response and memory-port signals
// between the snooping-bus controller (master) and the caches/memory (slave).
interface snoop_bus_ctrl_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  parameter int SRC_W   = 2
);
  logic [N_CORES-1:0]        req_valid;
  logic [2*N_CORES-1:0]      req_type;
  logic [ADDR_W*N_CORES-1:0] req_addr;
  logic [N_CORES-1:0]        grant;
  logic                      bus_valid;
  logic [1:0]                bus_type;
  logic [ADDR_W-1:0]         bus_addr;
  logic [SRC_W-1:0]          bus_src;
  logic [N_CORES-1:0]        share_in;
  logic [N_CORES-1:0]        flush_in;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ack;
  logic [N_CORES-1:0]        resp_valid;
  logic                      resp_shared;
  logic                      busy;

  modport master (
    input  req_valid, req_type, req_addr, share_in, flush_in, mem_ack,
    output grant, bus_valid, bus_type, bus_addr, bus_src,
           mem_req, mem_we, mem_addr, resp_valid, resp_shared, busy
  );

  modport slave (
    output req_valid, req_type, req_addr, share_in, flush_in, mem_ack,
    input  grant, bus_valid, bus_type, bus_addr, bus_src,
           mem_req, mem_we, mem_addr, resp_valid, resp_shared, busy
  );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Central snooping-bus controller: round-robin arbitration, action broadcast,
// snoop-response collection, optional memory transaction and completion.
module snoop_bus_ctrl #(
  parameter int N_CORES      = 4,
  parameter int ADDR_W       = 32,
  parameter int SRC_W        = 2,
  parameter int SNOOP_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  snoop_bus_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, MEM, DONE} state_t;
  typedef enum logic [1:0] {GETS = 2'd0, GETX = 2'd1, INV = 2'd2, PUTX = 2'd3} act_t;

  state_t             state;
  act_t               actType;
  logic [SRC_W-1:0]   rrPtr;
  logic [SRC_W-1:0]   src;
  logic [ADDR_W-1:0]  addr;
  logic [3:0]         snoopCnt;
  logic               shareAcc;
  logic               flushAcc;

  logic               pickValid;
  logic [SRC_W-1:0]   pick;
  logic [N_CORES-1:0] pickMask;
  logic [1:0]         pickType;
  logic [ADDR_W-1:0]  pickAddr;
  int unsigned        idx;

  logic [N_CORES-1:0] srcMask;
  logic               shareHit;
  logic               flushHit;
  logic [SRC_W-1:0]   rrNext;

  // First requester at or above rrPtr, wrapping past N_CORES-1 back to 0.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    pickMask  = '0;
    pickType  = '0;
    pickAddr  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      idx = 32'(rrPtr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!pickValid && bus.req_valid[idx]) begin
        pickValid     = 1'b1;
        pick          = SRC_W'(idx);
        pickMask[idx] = 1'b1;
        pickType      = bus.req_type[2*idx +: 2];
        pickAddr      = bus.req_addr[ADDR_W*idx +: ADDR_W];
      end
    end
  end

  always_comb begin
    srcMask      = '0;
    srcMask[src] = 1'b1;
    shareHit     = |(bus.share_in & ~srcMask);
    flushHit     = |(bus.flush_in & ~srcMask);
    rrNext       = (src == SRC_W'(N_CORES - 1)) ? '0 : src + SRC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      actType         <= GETS;
      rrPtr           <= '0;
      src             <= '0;
      addr            <= '0;
      snoopCnt        <= '0;
      shareAcc        <= 1'b0;
      flushAcc        <= 1'b0;
      bus.grant       <= '0;
      bus.bus_valid   <= 1'b0;
      bus.bus_type    <= '0;
      bus.bus_addr    <= '0;
      bus.bus_src     <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.resp_valid  <= '0;
      bus.resp_shared <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.grant       <= '0;
      bus.bus_valid   <= 1'b0;
      bus.resp_valid  <= '0;
      bus.resp_shared <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickValid) begin
            src           <= pick;
            actType       <= act_t'(pickType);
            addr          <= pickAddr;
            bus.grant     <= pickMask;
            bus.bus_valid <= 1'b1;
            bus.bus_type  <= pickType;
            bus.bus_addr  <= pickAddr;
            bus.bus_src   <= pick;
            bus.busy      <= 1'b1;
            state         <= BCAST;
          end
        end
        BCAST: begin
          shareAcc <= 1'b0;
          flushAcc <= 1'b0;
          snoopCnt <= 4'(SNOOP_CYCLES);
          state    <= SNOOP;
        end
        SNOOP: begin
          shareAcc <= shareAcc | shareHit;
          flushAcc <= flushAcc | flushHit;
          if (snoopCnt == 4'd1) begin
            if (actType == INV) begin
              bus.resp_valid <= srcMask;
              state          <= DONE;
            end else begin
              // The final-cycle flush sample is folded in here, not via flushAcc.
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= addr;
              bus.mem_we   <= (actType == PUTX) || flushAcc || flushHit;
              state        <= MEM;
            end
          end else begin
            snoopCnt <= snoopCnt - 4'd1;
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            bus.mem_req     <= 1'b0;
            bus.resp_valid  <= srcMask;
            bus.resp_shared <= (actType == GETS) && shareAcc;
            state           <= DONE;
          end
        end
        DONE: begin
          rrPtr    <= rrNext;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Randomized and directed bench for snoop_bus_ctrl against a transaction-level
// model of arbitration order, memory routing and the shared result.
module tb_snoop_bus_ctrl;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int SW = 2;
  localparam int SC = 2;

  localparam logic [1:0] T_GETS = 2'd0;
  localparam logic [1:0] T_GETX = 2'd1;
  localparam logic [1:0] T_INV  = 2'd2;
  localparam logic [1:0] T_PUTX = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  snoop_bus_ctrl_if #(.N_CORES(N), .ADDR_W(AW), .SRC_W(SW)) bif ();

  snoop_bus_ctrl #(.N_CORES(N), .ADDR_W(AW), .SRC_W(SW), .SNOOP_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int total = 0;
  int bad   = 0;

  int              mRr;
  logic [1:0]      mType [N];
  logic [AW-1:0]   mAddr [N];

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int modelPick(input logic [N-1:0] reqs, input int rr);
    for (int k = 0; k < N; k++)
      if (reqs[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int c, input logic [1:0] t, input logic [AW-1:0] a);
    mType[c] = t;
    mAddr[c] = a;
    bif.req_type[2*c +: 2]  = t;
    bif.req_addr[AW*c +: AW] = a;
  endtask

  task automatic runTxn(input logic [N-1:0] reqs, input int ackDelay,
                        input logic [SC*N-1:0] shr, input logic [SC*N-1:0] fl,
                        input bit junk);
    int w;
    int lat;
    logic [N-1:0] wMask;
    logic [N-1:0] s;
    logic [N-1:0] f;
    logic [1:0] t;
    bit anyShr;
    bit anyFl;
    bit expWe;
    bit expShared;
    w = modelPick(reqs, mRr);
    if (w < 0) return;
    wMask = '0;
    wMask[w] = 1'b1;
    t = mType[w];

    bif.req_valid = reqs;
    step();
    lat = 1;
    checkVal("grant", bif.grant, wMask);
    checkVal("bus_valid", bif.bus_valid, 1);
    checkVal("bus_type", bif.bus_type, t);
    checkVal("bus_addr", bif.bus_addr, mAddr[w]);
    checkVal("bus_src", bif.bus_src, w);
    checkVal("busy_bcast", bif.busy, 1);
    if (junk) begin
      bif.share_in = N'($urandom);
      bif.flush_in = N'($urandom);
      bif.mem_ack  = 1'($urandom_range(0, 1));
    end

    anyShr = 1'b0;
    anyFl  = 1'b0;
    for (int c = 0; c < SC; c++) begin
      step();
      lat++;
      if (c == 0) checkVal("pulses_drop", {bif.grant, bif.bus_valid}, '0);
      s = shr[c*N +: N];
      f = fl[c*N +: N];
      bif.share_in = s;
      bif.flush_in = f;
      if (|(s & ~wMask)) anyShr = 1'b1;
      if (|(f & ~wMask)) anyFl  = 1'b1;
      if (junk) bif.mem_ack = 1'($urandom_range(0, 1));
    end
    step();
    lat++;
    bif.share_in = junk ? N'($urandom) : '0;
    bif.flush_in = junk ? N'($urandom) : '0;
    bif.mem_ack  = 1'b0;

    expWe     = (t == T_PUTX) || anyFl;
    expShared = (t == T_GETS) && anyShr;
    if (t == T_INV) begin
      checkVal("inv_latency", lat, 2 + SC);
      checkVal("inv_no_mem", bif.mem_req, 0);
      checkVal("inv_resp", bif.resp_valid, wMask);
      checkVal("inv_shared", bif.resp_shared, 0);
    end else begin
      checkVal("mem_req", bif.mem_req, 1);
      checkVal("mem_we", bif.mem_we, expWe);
      checkVal("mem_addr", bif.mem_addr, mAddr[w]);
      checkVal("no_early_resp", bif.resp_valid, '0);
      for (int d = 0; d < ackDelay; d++) begin
        step();
        checkVal("mem_hold", {bif.mem_req, bif.busy, bif.resp_valid}, {2'b11, {N{1'b0}}});
      end
      bif.mem_ack = 1'b1;
      step();
      bif.mem_ack = 1'b0;
      checkVal("mem_drop", bif.mem_req, 0);
      checkVal("resp_valid", bif.resp_valid, wMask);
      checkVal("resp_shared", bif.resp_shared, expShared);
    end
    bif.req_valid = '0;
    step();
    checkVal("idle_after", {bif.busy, bif.resp_valid}, '0);
    mRr = (w + 1) % N;
  endtask

  initial begin
    bif.req_valid = '0;
    bif.req_type  = '0;
    bif.req_addr  = '0;
    bif.share_in  = '0;
    bif.flush_in  = '0;
    bif.mem_ack   = 1'b0;
    mRr = 0;
    for (int c = 0; c < N; c++) setReq(c, T_GETS, '0);

    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_state", {bif.grant, bif.bus_valid, bif.bus_type, bif.bus_addr, bif.bus_src,
             bif.mem_req, bif.mem_we, bif.mem_addr, bif.resp_valid, bif.resp_shared, bif.busy}, '0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Round robin over 1011 with INV only: expect cores 0,1,3,0.
    for (int c = 0; c < N; c++) setReq(c, T_INV, AW'(32'h1000 + c * 16));
    for (int i = 0; i < 4; i++) runTxn(4'b1011, 0, '0, '0, 1'b0);

    setReq(2, T_GETS, 32'h100);
    runTxn(4'b0100, 3, {4'b0001, 4'b0000}, '0, 1'b0);

    setReq(0, T_GETX, 32'h40);
    runTxn(4'b0001, 1, '0, {4'b1000, 4'b1000}, 1'b0);

    setReq(1, T_GETS, 32'h80);
    runTxn(4'b0010, 0, {4'b0010, 4'b0010}, {4'b0010, 4'b0010}, 1'b0);

    setReq(3, T_PUTX, 32'hFC);
    runTxn(4'b1000, 10, '0, '0, 1'b0);
    for (int c = 0; c < N; c++) setReq(c, T_INV, AW'(32'h2000 + c * 16));
    runTxn(4'b1111, 0, '0, '0, 1'b0);

    // Reset while core1's GETS sits in MEM, then rr pointer must restart at 0.
    setReq(1, T_GETS, 32'h200);
    bif.req_valid = 4'b0010;
    step();
    bif.req_valid = '0;
    repeat (3) step();
    checkVal("pre_reset_mem", bif.mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    checkVal("async_reset_outs", {bif.grant, bif.bus_valid, bif.bus_type, bif.bus_addr, bif.bus_src,
             bif.mem_req, bif.mem_we, bif.mem_addr, bif.resp_valid, bif.resp_shared, bif.busy}, '0);
    @(negedge clk);
    reset = 1'b1;
    mRr = 0;
    step();
    setReq(0, T_GETS, 32'h300);
    setReq(1, T_GETS, 32'h304);
    runTxn(4'b0011, 1, '0, '0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] reqs;
      logic [SC*N-1:0] shr;
      logic [SC*N-1:0] fl;
      for (int c = 0; c < N; c++) setReq(c, 2'($urandom), AW'($urandom));
      reqs = N'($urandom_range(1, (1 << N) - 1));
      shr  = (SC*N)'($urandom);
      fl   = (SC*N)'($urandom & $urandom & $urandom);
      runTxn(reqs, $urandom_range(0, 4), shr, fl, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/snoop_bus_ctrl.md
Name: snoop_bus_ctrl

Overview:
Central snooping-bus controller for the MESI caches: the responder/broadcaster side of the bus actions (GETS, GETX, INV, PUTX) issued by each per-line MESI controller.
- Arbitrates round-robin among N_CORES requesters.
- Broadcasts the winning action as the gets_obs/getx_obs/inv_obs source for all snoopers.
- Collects share/flush responses, performs the memory transaction when needed, and returns a completion with the share result.
- Sits between the per-core cache controllers and the memory port.

Parameters:
N_CORES, 4, number of requesting caches (2..8)
ADDR_W, 32, line address width
SRC_W, 2, width of the core index (must equal clog2(N_CORES))
SNOOP_CYCLES, 2, cycles the snoop window stays open (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_CORES  per-core request; held high until granted
req_type  in  2*N_CORES  per-core action, core i at [2i+1:2i]: 0=GETS 1=GETX 2=INV 3=PUTX
req_addr  in  ADDR_W*N_CORES  per-core line address, core i at [ADDR_W*i +: ADDR_W]
grant  out  N_CORES  one-hot, one-cycle pulse to the winner
bus_valid  out  1  broadcast strobe, one cycle
bus_type  out  2  broadcast action, same encoding as req_type
bus_addr  out  ADDR_W  broadcast address
bus_src  out  SRC_W  index of the issuing core
share_in  in  N_CORES  snooper holds the line (S/E/M) during the snoop window
flush_in  in  N_CORES  snooper in M supplies the line (its putx) during the snoop window
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  ADDR_W  memory address; valid while mem_req
mem_ack  in  1  memory completion, one cycle
resp_valid  out  N_CORES  one-hot completion pulse to the requester
resp_shared  out  1  OR of other cores' share_in; valid with resp_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous) behaviour:
  - Forces state IDLE and round-robin pointer rr_ptr=0.
  - All outputs go to 0: grant, bus_valid, bus_type, bus_addr, bus_src, mem_req, mem_we, mem_addr, resp_valid, resp_shared, busy.
  - The transaction in flight is abandoned.
  - Release is synchronous to clk.
- State IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Latch src, type and addr.
  - Go to BCAST.
  - The decision uses the req_valid value sampled in that cycle.
- State BCAST (1 cycle):
  - grant[src]=1, bus_valid=1, bus_type/bus_addr/bus_src driven from the latch.
  - Clear the share_acc and flush_acc accumulators.
  - Load the snoop counter with SNOOP_CYCLES.
  - Go to SNOOP.
- State SNOOP (exactly SNOOP_CYCLES cycles):
  - Each cycle: share_acc |= OR(share_in & ~onehot(src)) and flush_acc |= OR(flush_in & ~onehot(src)).
  - The requester's own share_in and flush_in bits are ignored.
  - Decrement the counter; exit when it reaches 1.
  - Exit routing:
    - INV -> DONE (no memory access).
    - PUTX -> MEM with mem_we=1.
    - GETS/GETX with flush_acc=1 -> MEM with mem_we=1 (writeback of the flushed line; data moves cache-to-cache).
    - GETS/GETX with flush_acc=0 -> MEM with mem_we=0.
- State MEM:
  - mem_req=1; mem_addr=latched addr; mem_we as chosen at SNOOP exit.
  - Remain until mem_ack=1 is sampled, then go to DONE.
  - mem_req drops in the cycle after the ack.
  - There is no timeout.
- State DONE (1 cycle):
  - resp_valid[src]=1.
  - resp_shared=share_acc for GETS; 0 for all other types.
  - rr_ptr <= (src+1) mod N_CORES, wrapping from N_CORES-1 to 0.
  - Go to IDLE.
- Latency:
  - Minimum request-to-resp_valid with no memory access (INV): 2+SNOOP_CYCLES cycles after the IDLE sampling edge.
  - Memory paths add 1 cycle plus the mem_ack wait.
- Request and ack rules:
  - req_valid of non-winners is ignored until the next IDLE.
  - A core that drops req_valid before grant simply loses its turn, with no error.
  - mem_ack outside MEM is ignored.
  - share_in/flush_in outside SNOOP are ignored.
- The requester may re-request in the cycle after resp_valid. Round-robin still gives lower-priority waiting cores precedence.
- grant, bus_valid and resp_valid are registered outputs, so they are glitch-free.

Test Plan:
1. Reset mid-MEM: core1 GETS, assert reset=0 during MEM -> same cycle: mem_req=0, busy=0, all outputs 0; after release, core0 GETS is granted first (rr_ptr=0).
2. Simultaneous req_valid=4'b1011 every cycle, all INV, SNOOP_CYCLES=2 -> grants in order core0, core1, core3, core0; resp_valid to each exactly 4 cycles after its IDLE sampling edge; no memory traffic.
3. Core2 GETS addr 0x100, share_in=4'b0001 in the 2nd snoop cycle only, flush_in=0 -> bus_type=0, bus_src=2; mem_req with mem_we=0, mem_addr=0x100; mem_ack after 3 cycles -> resp_valid=4'b0100, resp_shared=1.
4. Core0 GETX addr 0x40, flush_in=4'b1000 -> mem_we=1 write to 0x40; resp_valid[0]=1, resp_shared=0.
5. Self-response masking: core1 GETS with share_in=4'b0010 and flush_in=4'b0010 -> read path (mem_we=0), resp_shared=0.
6. Core3 PUTX addr 0xFC, mem_ack held 0 for 10 cycles -> mem_req stays 1, busy=1; ack -> resp_valid[3]=1; next winner is core0 (wrap-around).
